// File: rtl/daq_pkg.sv
// Shared types and constants for the DAQ acquisition sequencer.
package daq_pkg;

    localparam int DATA_NUMBER_W_DEF = 32;
    localparam int TRIG_CNT_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_READOUT = 3'd4,
        ST_DONE    = 3'd5
    } acq_state_t;

endpackage

// File: rtl/daq_acq_ctrl_if.sv
// Capture / readout handshake bundle between the sequencer (master) and the
// FIFO, AXI write path and readout engine (slave).
interface daq_acq_ctrl_if
    import daq_pkg::*;
#(
    parameter int DATA_NUMBER_W = DATA_NUMBER_W_DEF
);
    logic                     wr_beat;
    logic                     wr_idle;
    logic                     rd_ack;
    logic                     rd_done;
    logic                     capture_en;
    logic [7:0]               capture_mask;
    logic                     rd_req;
    logic [DATA_NUMBER_W-1:0] rd_len;

    modport master (
        input  wr_beat, wr_idle, rd_ack, rd_done,
        output capture_en, capture_mask, rd_req, rd_len
    );

    modport slave (
        output wr_beat, wr_idle, rd_ack, rd_done,
        input  capture_en, capture_mask, rd_req, rd_len
    );
endinterface

// File: rtl/daq_trig_sync.sv
// External trigger synchronizer: trigger_in and its qualifier each cross
// SYNC_STAGES flops; a registered rising edge of their AND gives ext_trig.
module daq_trig_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger_in,
    input  logic trigger_sync,
    output logic ext_trig
);
    logic [SYNC_STAGES-1:0] in_sync_reg;
    logic [SYNC_STAGES-1:0] qual_sync_reg;
    logic                   and_prev_reg;
    logic                   ext_trig_reg;
    logic                   and_now;

    assign and_now  = in_sync_reg[SYNC_STAGES-1] & qual_sync_reg[SYNC_STAGES-1];
    assign ext_trig = ext_trig_reg;

    // Synchronizer chains, then a registered one-cycle pulse on the AND's rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_sync_reg   <= '0;
            qual_sync_reg <= '0;
            and_prev_reg  <= 1'b0;
            ext_trig_reg  <= 1'b0;
        end else begin
            in_sync_reg[0]   <= trigger_in;
            qual_sync_reg[0] <= trigger_sync;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                in_sync_reg[i]   <= in_sync_reg[i-1];
                qual_sync_reg[i] <= qual_sync_reg[i-1];
            end
            and_prev_reg <= and_now;
            ext_trig_reg <= and_now & ~and_prev_reg;
        end
    end
endmodule

// File: rtl/daq_acq_ctrl.sv
// Acquisition sequencer: arm, trigger, gate capture of a programmed beat
// count, wait for AXI writes to retire, hand the length to readout.
// Optional capture watchdog enabled by defining ACQ_CTRL_TIMEOUT_EN.
module daq_acq_ctrl
    import daq_pkg::*;
#(
    parameter int DATA_NUMBER_W  = DATA_NUMBER_W_DEF,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                     clk,
    input  logic                     sys_rst,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     auto_rearm,
    input  logic                     trigger_in,
    input  logic                     trigger_sync,
    input  logic                     trigger_cmd,
    input  logic [DATA_NUMBER_W-1:0] data_number,
    input  logic [7:0]               channel_ctrl,
    daq_acq_ctrl_if.master           bus,
    output logic                     busy,
    output logic                     acq_done,
    output logic [TRIG_CNT_W-1:0]    trig_count,
    output logic [TRIG_CNT_W-1:0]    trig_missed,
    output logic                     timeout_err,
    output logic [2:0]               state
);
    acq_state_t               state_reg, state_next;
    logic [DATA_NUMBER_W-1:0] target_reg, beat_cnt_reg, rd_len_reg, beat_inc;
    logic [7:0]               mask_reg;
    logic                     capture_en_reg, rd_req_reg, acked_reg, acq_done_reg;
    logic [TRIG_CNT_W-1:0]    trig_count_reg, trig_missed_reg;
    logic                     ext_trig, trig, timeout_hit;

    daq_trig_sync #(.SYNC_STAGES(SYNC_STAGES)) u_trig_sync (
        .clk          (clk),
        .rst          (sys_rst),
        .trigger_in   (trigger_in),
        .trigger_sync (trigger_sync),
        .ext_trig     (ext_trig)
    );

    assign trig     = ext_trig | trigger_cmd;
    assign beat_inc = beat_cnt_reg + DATA_NUMBER_W'(1);

    // State register.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) state_reg <= ST_IDLE;
        else         state_reg <= state_next;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (arm && data_number != '0) state_next = ST_ARMED;
            ST_ARMED:   if (trig) state_next = ST_CAPTURE;
            ST_CAPTURE: begin
                if (bus.wr_beat && beat_inc == target_reg) state_next = ST_FLUSH;
                else if (timeout_hit)                      state_next = ST_IDLE;
            end
            ST_FLUSH:   if (bus.wr_idle) state_next = ST_READOUT;
            ST_READOUT: if (acked_reg && bus.rd_done) state_next = ST_DONE;
            ST_DONE:    state_next = auto_rearm ? ST_ARMED : ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (abort) state_next = ST_IDLE;
    end

    // Datapath: latched config, beat counting, readout handshake, trigger counters.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            target_reg      <= '0;
            mask_reg        <= '0;
            beat_cnt_reg    <= '0;
            rd_len_reg      <= '0;
            capture_en_reg  <= 1'b0;
            rd_req_reg      <= 1'b0;
            acked_reg       <= 1'b0;
            acq_done_reg    <= 1'b0;
            trig_count_reg  <= '0;
            trig_missed_reg <= '0;
        end else begin
            capture_en_reg <= (state_next == ST_CAPTURE);
            acq_done_reg   <= (state_next == ST_DONE);

            if (state_reg == ST_IDLE && state_next == ST_ARMED) begin
                target_reg   <= data_number;
                mask_reg     <= channel_ctrl;
                beat_cnt_reg <= '0;
            end else if (state_reg == ST_DONE && state_next == ST_ARMED) begin
                beat_cnt_reg <= '0;
            end else if (state_reg == ST_CAPTURE && bus.wr_beat) begin
                beat_cnt_reg <= beat_inc;
            end

            if (state_reg == ST_FLUSH && state_next == ST_READOUT)
                rd_len_reg <= beat_cnt_reg;

            // rd_req and the ack flag live only while READOUT is the next state.
            if (state_next != ST_READOUT) begin
                rd_req_reg <= 1'b0;
                acked_reg  <= 1'b0;
            end else if (state_reg == ST_FLUSH) begin
                rd_req_reg <= 1'b1;
            end else if (rd_req_reg && bus.rd_ack) begin
                rd_req_reg <= 1'b0;
                acked_reg  <= 1'b1;
            end

            if (state_reg == ST_ARMED && state_next == ST_CAPTURE)
                trig_count_reg <= trig_count_reg + TRIG_CNT_W'(1);
            if (trig && state_reg != ST_ARMED && trig_missed_reg != '1)
                trig_missed_reg <= trig_missed_reg + TRIG_CNT_W'(1);
        end
    end

`ifdef ACQ_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_reg;
    logic            timeout_err_reg;

    assign timeout_hit = !bus.wr_beat && (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_err_reg;

    // Watchdog: cycles spent in CAPTURE since the last beat; sticky error until next arm.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg != ST_CAPTURE || bus.wr_beat) wd_cnt_reg <= '0;
            else                                        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);

            if (state_reg == ST_IDLE && state_next == ST_ARMED)
                timeout_err_reg <= 1'b0;
            else if (state_reg == ST_CAPTURE && timeout_hit && !abort)
                timeout_err_reg <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    assign bus.capture_en   = capture_en_reg;
    assign bus.capture_mask = mask_reg;
    assign bus.rd_req       = rd_req_reg;
    assign bus.rd_len       = rd_len_reg;
    assign busy             = (state_reg != ST_IDLE);
    assign acq_done         = acq_done_reg;
    assign trig_count       = trig_count_reg;
    assign trig_missed      = trig_missed_reg;
    assign state            = state_reg;
endmodule

// File: tb/tb_daq_acq_ctrl.sv
// Self-checking bench for daq_acq_ctrl: a table of per-cycle vectors whose
// expected outputs go through a scoreboard queue, plus hand-written sequences
// for auto-rearm, external trigger latency and the optional watchdog.
module tb_daq_acq_ctrl;
    import daq_pkg::*;

    localparam int W  = 32;
    localparam int SS = 2;

    typedef struct {
        logic        arm, abort, tcmd, beat, widle, ack, done;
        logic [31:0] dn;
        logic [2:0]  e_state;
        logic        e_cap, e_req, e_done;
        logic [15:0] e_tc, e_tm;
    } vec_t;

    logic         clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         arm = 0, abort = 0, auto_rearm = 0;
    logic         trigger_in = 0, trigger_sync = 0, trigger_cmd = 0;
    logic [W-1:0] data_number = '0;
    logic [7:0]   channel_ctrl = 8'hA5;
    logic         busy, acq_done, timeout_err;
    logic [15:0]  trig_count, trig_missed;
    logic [2:0]   state;

    int checks = 0;
    int failures = 0;
    int row_id = 0;
    int done_pulses = 0;
    vec_t exp_q[$];
    vec_t tbl[28];

    daq_acq_ctrl_if #(.DATA_NUMBER_W(W)) bus_if ();

    daq_acq_ctrl #(
        .DATA_NUMBER_W  (W),
        .SYNC_STAGES    (SS),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .arm          (arm),
        .abort        (abort),
        .auto_rearm   (auto_rearm),
        .trigger_in   (trigger_in),
        .trigger_sync (trigger_sync),
        .trigger_cmd  (trigger_cmd),
        .data_number  (data_number),
        .channel_ctrl (channel_ctrl),
        .bus          (bus_if),
        .busy         (busy),
        .acq_done     (acq_done),
        .trig_count   (trig_count),
        .trig_missed  (trig_missed),
        .timeout_err  (timeout_err),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic a, ab, tc, bt, wi, ak, dn_p, input logic [31:0] n,
                                input logic [2:0] st, input logic cap, req, dne,
                                input logic [15:0] etc, etm);
        vec_t v;
        v.arm = a; v.abort = ab; v.tcmd = tc; v.beat = bt; v.widle = wi; v.ack = ak; v.done = dn_p;
        v.dn = n; v.e_state = st; v.e_cap = cap; v.e_req = req; v.e_done = dne;
        v.e_tc = etc; v.e_tm = etm;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expected post-edge outputs, then release pulses.
    task automatic apply(input vec_t v);
        @(negedge clk);
        arm = v.arm; abort = v.abort; trigger_cmd = v.tcmd;
        bus_if.wr_beat = v.beat; bus_if.wr_idle = v.widle;
        bus_if.rd_ack = v.ack; bus_if.rd_done = v.done;
        data_number = v.dn;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        arm = 0; abort = 0; trigger_cmd = 0;
        bus_if.wr_beat = 0; bus_if.wr_idle = 0; bus_if.rd_ack = 0; bus_if.rd_done = 0;
    endtask

    // Scoreboard: compare each queued expectation just after the edge it applies to.
    always @(posedge clk) begin : monitor
        vec_t e;
        string tag;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tag = $sformatf("row%0d", row_id);
            $display("row %0d: state=%0d cap=%0b req=%0b done=%0b tc=%0d tm=%0d",
                     row_id, state, bus_if.capture_en, bus_if.rd_req, acq_done, trig_count, trig_missed);
            chk({tag, " state"}, 32'(state), 32'(e.e_state));
            chk({tag, " capture_en"}, 32'(bus_if.capture_en), 32'(e.e_cap));
            chk({tag, " rd_req"}, 32'(bus_if.rd_req), 32'(e.e_req));
            chk({tag, " acq_done"}, 32'(acq_done), 32'(e.e_done));
            chk({tag, " busy"}, 32'(busy), 32'(e.e_state != 3'd0));
            chk({tag, " trig_count"}, 32'(trig_count), 32'(e.e_tc));
            chk({tag, " trig_missed"}, 32'(trig_missed), 32'(e.e_tm));
            if (acq_done) done_pulses++;
            row_id++;
        end
    end

    initial begin
        int lat, cnt, dp0;
        bus_if.wr_beat = 0; bus_if.wr_idle = 0; bus_if.rd_ack = 0; bus_if.rd_done = 0;

        //               arm ab tc bt wi ak dn  n   state       cap req dne tc tm
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, ST_IDLE,    0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, ST_IDLE,    0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 4, ST_ARMED,   0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 4, ST_ARMED,   0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 0, 0, 0, 0, 4, ST_CAPTURE, 1, 0, 0, 1, 0);
        tbl[5]  = mk(0, 0, 0, 1, 0, 0, 0, 4, ST_CAPTURE, 1, 0, 0, 1, 0);
        tbl[6]  = mk(0, 0, 1, 1, 0, 0, 0, 4, ST_CAPTURE, 1, 0, 0, 1, 1);
        tbl[7]  = mk(0, 0, 0, 1, 0, 0, 0, 4, ST_CAPTURE, 1, 0, 0, 1, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 4, ST_CAPTURE, 1, 0, 0, 1, 1);
        tbl[9]  = mk(0, 0, 0, 1, 0, 0, 0, 4, ST_FLUSH,   0, 0, 0, 1, 1);
        tbl[10] = mk(0, 0, 1, 0, 0, 0, 0, 4, ST_FLUSH,   0, 0, 0, 1, 2);
        tbl[11] = mk(0, 0, 1, 1, 0, 0, 0, 4, ST_FLUSH,   0, 0, 0, 1, 3);
        tbl[12] = mk(0, 0, 0, 0, 1, 0, 0, 4, ST_READOUT, 0, 1, 0, 1, 3);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 4, ST_READOUT, 0, 1, 0, 1, 3);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, 4, ST_READOUT, 0, 0, 0, 1, 3);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 4, ST_READOUT, 0, 0, 0, 1, 3);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 4, ST_DONE,    0, 0, 1, 1, 3);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 4, ST_IDLE,    0, 0, 0, 1, 3);
        tbl[18] = mk(1, 0, 0, 0, 0, 0, 0, 8, ST_ARMED,   0, 0, 0, 1, 3);
        tbl[19] = mk(0, 0, 1, 0, 0, 0, 0, 8, ST_CAPTURE, 1, 0, 0, 2, 3);
        tbl[20] = mk(0, 0, 0, 1, 0, 0, 0, 8, ST_CAPTURE, 1, 0, 0, 2, 3);
        tbl[21] = mk(0, 0, 0, 1, 0, 0, 0, 8, ST_CAPTURE, 1, 0, 0, 2, 3);
        tbl[22] = mk(1, 1, 0, 1, 0, 0, 0, 8, ST_IDLE,    0, 0, 0, 2, 3);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 8, ST_IDLE,    0, 0, 0, 2, 3);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 1, 8, ST_IDLE,    0, 0, 0, 2, 3);
        tbl[25] = mk(0, 0, 1, 0, 0, 0, 0, 8, ST_IDLE,    0, 0, 0, 2, 4);
        tbl[26] = mk(1, 0, 0, 0, 0, 0, 0, 3, ST_ARMED,   0, 0, 0, 2, 4);
        tbl[27] = mk(0, 1, 0, 0, 0, 0, 0, 3, ST_IDLE,    0, 0, 0, 2, 4);

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        sys_rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset state", 32'(state), 32'(ST_IDLE));
        chk("reset capture_en", 32'(bus_if.capture_en), 0);
        chk("reset rd_req", 32'(bus_if.rd_req), 0);
        chk("reset rd_len", bus_if.rd_len, 0);
        chk("reset capture_mask", 32'(bus_if.capture_mask), 0);
        chk("reset acq_done", 32'(acq_done), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset trig_count", 32'(trig_count), 0);
        chk("reset trig_missed", 32'(trig_missed), 0);
        chk("reset timeout_err", 32'(timeout_err), 0);

        // Normal run, missed triggers, abort mid-capture.
        for (int i = 0; i < 28; i++) begin
            apply(tbl[i]);
            if (i == 17) begin
                chk("normal rd_len", bus_if.rd_len, 4);
                chk("normal capture_mask", 32'(bus_if.capture_mask), 32'hA5);
                chk("normal acq_done pulses", 32'(done_pulses), 1);
            end
        end
        chk("abort rd_len kept", bus_if.rd_len, 4);

        // Auto-rearm: second capture reuses target and mask without a new arm.
        auto_rearm = 1'b1;
        channel_ctrl = 8'h3C;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 2, ST_ARMED, 0, 0, 0, 2, 4));
        channel_ctrl = 8'hFF;
        dp0 = done_pulses;
        for (int r = 0; r < 2; r++) begin
            apply(mk(0, 0, 1, 0, 0, 0, 0, 7, ST_CAPTURE, 1, 0, 0, 16'(3 + r), 4));
            apply(mk(0, 0, 0, 1, 0, 0, 0, 7, ST_CAPTURE, 1, 0, 0, 16'(3 + r), 4));
            apply(mk(0, 0, 0, 1, 0, 0, 0, 7, ST_FLUSH,   0, 0, 0, 16'(3 + r), 4));
            apply(mk(0, 0, 0, 0, 1, 0, 0, 7, ST_READOUT, 0, 1, 0, 16'(3 + r), 4));
            apply(mk(0, 0, 0, 0, 0, 1, 0, 7, ST_READOUT, 0, 0, 0, 16'(3 + r), 4));
            apply(mk(0, 0, 0, 0, 0, 0, 1, 7, ST_DONE,    0, 0, 1, 16'(3 + r), 4));
            apply(mk(0, 0, 0, 0, 0, 0, 0, 7, ST_ARMED,   0, 0, 0, 16'(3 + r), 4));
            chk($sformatf("rearm%0d rd_len", r), bus_if.rd_len, 2);
            chk($sformatf("rearm%0d capture_mask", r), 32'(bus_if.capture_mask), 32'h3C);
        end
        chk("rearm acq_done pulses", 32'(done_pulses - dp0), 2);
        auto_rearm = 1'b0;
        apply(mk(0, 1, 0, 0, 0, 0, 0, 7, ST_IDLE, 0, 0, 0, 4, 4));

        // External trigger: qualified rising edge reaches capture_en after SS+2 edges.
        trigger_sync = 1'b1;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 1, ST_ARMED, 0, 0, 0, 4, 4));
        @(negedge clk);
        trigger_in = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus_if.capture_en) begin
                lat = c;
                break;
            end
        end
        $display("ext trigger: capture_en after %0d cycles", lat);
        chk("ext_trig latency", 32'(lat), 32'(SS + 2));
        apply(mk(0, 1, 0, 0, 0, 0, 0, 1, ST_IDLE, 0, 0, 0, 5, 4));
        trigger_in = 1'b0;
        trigger_sync = 1'b0;
        repeat (4) @(posedge clk);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 1, ST_ARMED, 0, 0, 0, 5, 4));
        @(negedge clk);
        trigger_in = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus_if.capture_en) cnt++;
        end
        $display("unqualified trigger: %0d capture cycles", cnt);
        chk("unqualified trig capture cycles", 32'(cnt), 0);
        chk("unqualified trig state", 32'(state), 32'(ST_ARMED));
        apply(mk(0, 1, 0, 0, 0, 0, 0, 1, ST_IDLE, 0, 0, 0, 5, 4));
        trigger_in = 1'b0;

`ifdef ACQ_CTRL_TIMEOUT_EN
        // Watchdog: no beats after the trigger; back to IDLE after 16 capture cycles.
        apply(mk(1, 0, 0, 0, 0, 0, 0, 5, ST_ARMED,   0, 0, 0, 5, 4));
        apply(mk(0, 0, 1, 0, 0, 0, 0, 5, ST_CAPTURE, 1, 0, 0, 6, 4));
        cnt = 1;
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (acq_done || bus_if.rd_req) lat++;
            if (state != ST_CAPTURE) break;
            cnt++;
        end
        $display("timeout: %0d capture cycles, err=%0b", cnt, timeout_err);
        chk("timeout capture cycles", 32'(cnt), 16);
        chk("timeout state", 32'(state), 32'(ST_IDLE));
        chk("timeout_err set", 32'(timeout_err), 1);
        chk("timeout no readout", 32'(lat), 0);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 5, ST_ARMED, 0, 0, 0, 6, 4));
        chk("timeout_err cleared by arm", 32'(timeout_err), 0);
        apply(mk(0, 1, 0, 0, 0, 0, 0, 5, ST_IDLE, 0, 0, 0, 6, 4));
`else
        chk("timeout_err tied low", 32'(timeout_err), 0);
`endif

        chk("scoreboard drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/daq_acq_ctrl.md
# daq_acq_ctrl

Acquisition sequencer for the DAQ datapath, clocked by the 200 MHz AXI/ui clock. It arms on command and accepts a synchronized external or SiTCP trigger. It gates the deep FIFO's capture of a programmed number of 512-bit write beats into DDR3, then waits for all AXI writes to retire. Finally it hands the captured length to the readout engine and reports completion.

## Interface
Parameters:
- DATA_NUMBER_W, 32: width of beat-count target and counters
- SYNC_STAGES, 2: synchronizer depth for external trigger inputs
- TIMEOUT_CYCLES, 1048576: capture watchdog limit (used only with macro)

Ports:
- clk  in  1  single clock for the whole block (ui_clk, 200 MHz)
- sys_rst  in  1  asynchronous, active-high reset
- arm  in  1  one-cycle pulse: IDLE -> ARMED
- abort  in  1  one-cycle pulse: any state -> IDLE
- auto_rearm  in  1  level: after DONE return to ARMED instead of IDLE
- trigger_in  in  1  asynchronous external trigger
- trigger_sync  in  1  asynchronous external trigger qualifier
- trigger_cmd  in  1  clk-synchronous one-cycle software trigger
- data_number  in  DATA_NUMBER_W  beats to capture, sampled on arm
- channel_ctrl  in  8  channel enable mask, sampled on arm
- wr_beat  in  1  pulse per accepted AXI write beat (wvalid & wready)
- wr_idle  in  1  high when no AXI write response is outstanding
- rd_ack  in  1  readout engine accepted request
- rd_done  in  1  one-cycle pulse: readout finished
- capture_en  out  1  enables FIFO capture
- capture_mask  out  8  latched channel_ctrl
- rd_req  out  1  readout request, held until rd_ack
- rd_len  out  DATA_NUMBER_W  beats captured
- busy  out  1  state != IDLE
- acq_done  out  1  one-cycle completion pulse
- trig_count  out  16  accepted triggers, wraps
- trig_missed  out  16  triggers seen outside ARMED, saturates at 0xFFFF
- timeout_err  out  1  sticky watchdog flag, cleared on arm
- state  out  3  current state encoding

## Operation
- States: IDLE(0), ARMED(1), CAPTURE(2), FLUSH(3), READOUT(4), DONE(5).
- Trigger path: trigger_in and trigger_sync each pass through SYNC_STAGES flops. A rising edge of their AND produces a one-cycle ext_trig. trig = ext_trig | trigger_cmd.
- IDLE: when arm is high and data_number != 0, latch target and mask, clear beat_cnt and timeout_err, and go to ARMED. When arm is high and data_number == 0, ignore it and stay in IDLE.
- ARMED: on trig, increment trig_count and go to CAPTURE.
- CAPTURE: wr_beat increments beat_cnt. When wr_beat arrives and beat_cnt+1 == target, go to FLUSH.
- FLUSH: when wr_idle == 1, load rd_len = beat_cnt and go to READOUT.
- READOUT: rd_req is high until rd_ack is sampled. After rd_ack, wait for rd_done, then go to DONE.
- DONE: acq_done = 1 for one cycle. Next state is ARMED if auto_rearm, else IDLE. The rearm path clears beat_cnt and keeps target and mask.
- Boundary behaviour:
  - trig outside ARMED increments trig_missed and is otherwise ignored.
  - wr_beat outside CAPTURE is ignored.
  - rd_done before rd_ack is ignored.
  - abort has priority over every other transition. It takes effect even when arm or trig is present in the same cycle.
  - abort returns to IDLE next cycle, with capture_en, rd_req and acq_done low. A later rd_done is ignored.

## Timing
- Reset values: state IDLE, all outputs 0, all counters 0.
- Latency from trigger_cmd to capture_en: 1 cycle.
- Latency from a trigger_in edge to capture_en: SYNC_STAGES+2 cycles.
- capture_en is registered and equals (state == CAPTURE). It falls in the cycle after the final wr_beat.
- rd_req rises in the cycle after wr_idle is sampled high in FLUSH.
- rd_len is stable while rd_req is high.
- beat_cnt is full width and wraps; target == 2^W-1 is legal.

## Configuration
- ACQ_CTRL_TIMEOUT_EN defined:
  - A watchdog counts cycles in CAPTURE since the last wr_beat.
  - When it reaches TIMEOUT_CYCLES, set timeout_err and go to IDLE (no readout, no acq_done).
- ACQ_CTRL_TIMEOUT_EN undefined:
  - No watchdog; CAPTURE waits indefinitely.
  - timeout_err is tied to 0.

## Structure
- Shared package daq_pkg holds:
  - the acq_state_t enum with the encodings above
  - DATA_NUMBER_W default
  - the trig_count and trig_missed width constant
- Sub-module daq_trig_sync: SYNC_STAGES synchronizer plus the rising-edge detector, producing ext_trig.

## Test plan
- Normal run: arm with data_number=4, trigger_cmd, 4 wr_beat, wr_idle=1, then rd_ack and rd_done. Required: capture_en high for exactly the capture window, rd_len=4, one acq_done pulse, trig_count=1, return to IDLE.
- External trigger: trigger_sync=1 and a rising edge on trigger_in. Required: capture_en rises SYNC_STAGES+2 cycles after the edge. With trigger_sync=0 there must be no capture.
- Missed triggers: 3 trigger_cmd pulses in CAPTURE/FLUSH. Required: trig_missed=3, trig_count unchanged.
- Abort mid-CAPTURE after 2 of 8 beats, with arm asserted in the same cycle. Required: IDLE next cycle, capture_en=0, no rd_req, no acq_done.
- auto_rearm=1 with two triggers. Required: two acq_done pulses, and the second capture uses the same target and mask without a new arm.
- With ACQ_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, and no beats after the trigger. Required: timeout_err=1 and IDLE after 16 cycles. The next arm clears timeout_err.
